// File: rtl/router_input_port.sv
// Router input port: DEPTH-entry flit FIFO with XY route computation on the head
// flit, registered credit return and a sticky overflow flag.
module router_input_port #(
  parameter int          FLIT_W = 64,
  parameter int          DEPTH  = 4,
  parameter logic [7:0]  X_ID   = 8'd0,
  parameter logic [7:0]  Y_ID   = 8'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        flit_in,
  input  logic                     valid_in,
  output logic                     credit_out,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     valid_out,
  output logic [4:0]               route_out,
  input  logic                     grant_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] ROUTE_L = 5'b00001;
  localparam logic [4:0] ROUTE_N = 5'b00010;
  localparam logic [4:0] ROUTE_S = 5'b00100;
  localparam logic [4:0] ROUTE_E = 5'b01000;
  localparam logic [4:0] ROUTE_W = 5'b10000;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [FLIT_W-1:0] head;
  logic [7:0]        dest_x;
  logic [7:0]        dest_y;

  logic full;
  logic deq;
  logic enq;
  logic drop;

  // Handshake: the head flit transfers on any edge where valid_out and grant_in
  // are both high; grant_in without valid_out has no effect. Upstream flow control
  // is credit based, so valid_in is never back-pressured here: a flit arriving at
  // a full buffer with no same-cycle dequeue is dropped and flagged.
  assign full = (count == CNT_W'(DEPTH));
  assign deq  = grant_in && valid_out;
  assign enq  = valid_in && (!full || deq);
  assign drop = valid_in && full && !deq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (deq && !enq) count <= count - CNT_W'(1);
    end
  end

  // Storage is deliberately left unreset; only pointers and count carry state.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_out   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      credit_out <= deq;
      if (drop) overflow_err <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign dest_x    = head[7:0];
  assign dest_y    = head[15:8];
  assign valid_out = (count != '0);
  assign count_out = count;

  // Gating on rst keeps flit_out at zero during reset even though storage is not reset.
  assign flit_out = rst ? '0 : head;

  // Dimension-ordered routing: resolve X fully before Y; comparisons are unsigned.
  always_comb begin
    route_out = '0;
    if (valid_out) begin
      if (dest_x > X_ID)      route_out = ROUTE_E;
      else if (dest_x < X_ID) route_out = ROUTE_W;
      else if (dest_y > Y_ID) route_out = ROUTE_S;
      else if (dest_y < Y_ID) route_out = ROUTE_N;
      else                    route_out = ROUTE_L;
    end
  end

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port at tile (1,1): directed routing/fill/overflow/reset
// sequences plus a random stream checked against a flit scoreboard.
module tb_router_input_port;

  localparam int FLIT_W = 64;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  localparam logic [4:0] R_L = 5'b00001;
  localparam logic [4:0] R_N = 5'b00010;
  localparam logic [4:0] R_S = 5'b00100;
  localparam logic [4:0] R_E = 5'b01000;
  localparam logic [4:0] R_W = 5'b10000;

  logic              clk;
  logic              rst;
  logic [FLIT_W-1:0] flit_in;
  logic              valid_in;
  logic              credit_out;
  logic [FLIT_W-1:0] flit_out;
  logic              valid_out;
  logic [4:0]        route_out;
  logic              grant_in;
  logic [CNT_W-1:0]  count_out;
  logic              overflow_err;

  router_input_port #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .X_ID(8'd1), .Y_ID(8'd1)
  ) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .valid_in(valid_in),
    .credit_out(credit_out), .flit_out(flit_out), .valid_out(valid_out),
    .route_out(route_out), .grant_in(grant_in), .count_out(count_out),
    .overflow_err(overflow_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [7:0] x, input logic [7:0] y,
                                          input logic [47:0] tag);
    return {tag, y, x};
  endfunction

  // Reference XY router for tile (1,1)
  function automatic logic [4:0] ref_route(input logic [FLIT_W-1:0] f);
    logic [7:0] x;
    logic [7:0] y;
    x = f[7:0];
    y = f[15:8];
    if (x > 8'd1)      return R_E;
    else if (x < 8'd1) return R_W;
    else if (y > 8'd1) return R_S;
    else if (y < 8'd1) return R_N;
    else               return R_L;
  endfunction

  // scoreboard + occupancy model, evaluated on the falling edge
  logic [FLIT_W-1:0] exp_q[$];
  logic [4:0]        exp_route_q[$];
  int   model_cnt  = 0;
  logic model_ovf  = 1'b0;
  logic prev_deq   = 1'b0;
  int   credit_cnt = 0;
  int   pop_cnt    = 0;
  int   max_cnt    = 0;

  always @(negedge clk) begin
    logic deq_m;
    logic enq_m;
    logic [FLIT_W-1:0] ef;
    logic [4:0]        er;
    if (rst) begin
      exp_q.delete();
      exp_route_q.delete();
      model_cnt = 0;
      model_ovf = 1'b0;
      prev_deq  = 1'b0;
    end else begin
      chk("count", 64'(count_out), 64'(model_cnt));
      chk("credit", 64'(credit_out), 64'(prev_deq));
      chk("overflow", 64'(overflow_err), 64'(model_ovf));
      if (credit_out) credit_cnt++;
      if (int'(count_out) > max_cnt) max_cnt = int'(count_out);
      deq_m = grant_in && (model_cnt != 0);
      enq_m = valid_in && ((model_cnt < DEPTH) || deq_m);
      if (valid_in && !enq_m) model_ovf = 1'b1;
      if (deq_m) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          ef = exp_q.pop_front();
          er = exp_route_q.pop_front();
          chk("sb_valid", 64'(valid_out), 64'd1);
          chk("sb_flit", flit_out, ef);
          chk("sb_route", 64'(route_out), 64'(er));
          pop_cnt++;
        end
      end
      if (enq_m) begin
        exp_q.push_back(flit_in);
        exp_route_q.push_back(ref_route(flit_in));
      end
      model_cnt = model_cnt + int'(enq_m) - int'(deq_m);
      prev_deq  = deq_m;
    end
  end

  // driver: apply inputs for the next edge, then return 1 time unit after it
  task automatic cycle(input logic v, input logic [FLIT_W-1:0] f, input logic g);
    valid_in = v;
    flit_in  = f;
    grant_in = g;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [FLIT_W-1:0] flit;
    logic [4:0]        route;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int sent;
    logic v;
    logic g;

    vecs[0] = '{mk(8'd3,   8'd1,   48'h100), R_E};
    vecs[1] = '{mk(8'd0,   8'd1,   48'h101), R_W};
    vecs[2] = '{mk(8'd1,   8'd0,   48'h102), R_N};
    vecs[3] = '{mk(8'd1,   8'd2,   48'h103), R_S};
    vecs[4] = '{mk(8'd1,   8'd1,   48'h104), R_L};
    vecs[5] = '{mk(8'd255, 8'd1,   48'h105), R_E};
    vecs[6] = '{mk(8'd1,   8'd255, 48'h106), R_S};
    vecs[7] = '{mk(8'd0,   8'd200, 48'h107), R_W};

    rst = 1'b1;
    valid_in = 1'b0;
    grant_in = 1'b0;
    flit_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_route", 64'(route_out), 64'd0);
    chk("rst_credit", 64'(credit_out), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_flit", flit_out, 64'd0);
    #2 rst = 1'b0;

    // single flit, grant held high from the start
    cycle(1'b1, mk(8'd3, 8'd1, 48'hA0), 1'b1);
    chk("s1_valid", 64'(valid_out), 64'd1);
    chk("s1_route", 64'(route_out), 64'(R_E));
    chk("s1_credit0", 64'(credit_out), 64'd0);
    cycle(1'b0, '0, 1'b1);
    chk("s1_credit1", 64'(credit_out), 64'd1);
    chk("s1_empty", 64'(valid_out), 64'd0);
    chk("s1_route_idle", 64'(route_out), 64'd0);
    cycle(1'b0, '0, 1'b1);
    chk("s1_credit2", 64'(credit_out), 64'd0);

    // table: stream through with grant high, head must be the latest flit
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vecs[i].flit, 1'b1);
      chk($sformatf("tbl_flit%0d", i), flit_out, vecs[i].flit);
      chk($sformatf("tbl_route%0d", i), 64'(route_out), 64'(vecs[i].route));
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // full buffer with simultaneous enqueue and dequeue
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(8'd2, 8'd2, 48'h200 + 48'(i)), 1'b0);
    chk("s4_full", 64'(count_out), 64'd4);
    cycle(1'b1, mk(8'd1, 8'd0, 48'h2FF), 1'b1);
    chk("s4_count", 64'(count_out), 64'd4);
    chk("s4_ovf", 64'(overflow_err), 64'd0);
    chk("s4_credit", 64'(credit_out), 64'd1);
    cycle(1'b0, '0, 1'b0);
    chk("s4_credit_end", 64'(credit_out), 64'd0);
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("s4_drained", 64'(count_out), 64'd0);
    cycle(1'b0, '0, 1'b0);

    // overflow: fifth flit dropped, originals drain intact
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(8'd0, 8'd0, 48'h300 + 48'(i)), 1'b0);
    cycle(1'b1, mk(8'd5, 8'd5, 48'h3FF), 1'b0);
    chk("s3_count", 64'(count_out), 64'd4);
    chk("s3_ovf", 64'(overflow_err), 64'd1);
    chk("s3_head", flit_out, mk(8'd0, 8'd0, 48'h300));
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("s3_drained", 64'(count_out), 64'd0);
    chk("s3_ovf_sticky", 64'(overflow_err), 64'd1);

    // reset mid-operation with a credit pulse pending
    cycle(1'b1, mk(8'd3, 8'd3, 48'h400), 1'b0);
    cycle(1'b1, mk(8'd3, 8'd3, 48'h401), 1'b0);
    cycle(1'b1, mk(8'd3, 8'd3, 48'h402), 1'b1);
    chk("s5_credit_pre", 64'(credit_out), 64'd1);
    #2;
    rst = 1'b1;
    valid_in = 1'b0;
    grant_in = 1'b0;
    #1;
    chk("s5_valid", 64'(valid_out), 64'd0);
    chk("s5_count", 64'(count_out), 64'd0);
    chk("s5_flit", flit_out, 64'd0);
    chk("s5_route", 64'(route_out), 64'd0);
    chk("s5_credit", 64'(credit_out), 64'd0);
    chk("s5_ovf", 64'(overflow_err), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("s5_no_credit", 64'(credit_out), 64'd0);
      chk("s5_no_valid", 64'(valid_out), 64'd0);
    end

    // random stream: 64 flits, random grants, never overfill
    credit_cnt = 0;
    pop_cnt = 0;
    max_cnt = 0;
    sent = 0;
    while (sent < 64) begin
      v = ($urandom_range(0, 3) != 0);
      g = 1'(($urandom_range(0, 1)));
      if (model_cnt == DEPTH && !g) v = 1'b0;
      if (v) sent++;
      cycle(v, {$urandom(), $urandom()}, g);
    end
    n = 0;
    while (model_cnt != 0 && n < 20) begin
      cycle(1'b0, '0, 1'b1);
      n++;
    end
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("rnd_drain_bound", 64'(model_cnt), 64'd0);
    chk("rnd_pops", 64'(pop_cnt), 64'd64);
    chk("rnd_credits", 64'(credit_cnt), 64'd64);
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rnd_max_count", 64'(max_cnt <= DEPTH), 64'd1);
    chk("rnd_no_ovf", 64'(overflow_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
